dmem_io_responder: RTL and testbench

//   Responder end of the core's data-memory port (Address/WriteData/MemWrite/ReadData).

---
 rtl/dmem_io_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_dmem_io_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_io_responder.sv
// dmem_io_responder: responder end of the core's data-memory port.
// Address[22]=0 selects word RAM, Address[22]=1 selects the IO page
// (LEDs, UART TX FIFO + 8N1 serializer, status, free-running cycle counter).
// ReadData is combinational so the core can sample it late in its M stage.
//
// TX FSM states
//   state   | meaning
//   S_IDLE  | line high; pops the FIFO head into the shift register when non-empty
//   S_START | start bit, line low for CLK_DIV clocks
//   S_DATA  | data bits LSB first, CLK_DIV clocks each
//   S_STOP  | stop bit, line high for CLK_DIV clocks
module dmem_io_responder #(
    parameter int MEM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST      = DW'(CLK_DIV - 1);
    localparam logic [FW:0]   FIFO_FULL_CNT = (FW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    logic [31:0]   r_mem  [MEM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [FW-1:0] r_wr_ptr;
    logic [FW-1:0] r_rd_ptr;
    logic [FW:0]   r_count;
    logic          r_ovf;
    logic [7:0]    r_leds;
    logic [31:0]   r_cycle;
    tx_state_t     r_state;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic          w_io;
    logic [1:0]    w_sel;
    logic [AW-1:0] w_ram_idx;
    logic          w_wr_ram;
    logic          w_wr_led;
    logic          w_push_req;
    logic          w_wr_status;
    logic          w_wr_cycle;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_busy;
    logic [31:0]   w_status;
    logic          w_unused_addr;

    assign w_io      = Address[22];
    assign w_sel     = Address[3:2];
    assign w_ram_idx = Address[AW+1:2];

    // Byte-lane and upper address bits are don't-care (RAM aliases, IO page mirrors).
    assign w_unused_addr = ^Address;

    assign w_wr_ram    = MemWrite & ~w_io;
    assign w_wr_led    = MemWrite & w_io & (w_sel == 2'd0);
    assign w_push_req  = MemWrite & w_io & (w_sel == 2'd1);
    assign w_wr_status = MemWrite & w_io & (w_sel == 2'd2);
    assign w_wr_cycle  = MemWrite & w_io & (w_sel == 2'd3);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FIFO_FULL_CNT);
    assign w_pop   = (r_state == S_IDLE) & ~w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_busy  = (r_state != S_IDLE) | ~w_empty;

    assign w_status = {19'd0, 5'(r_count), 4'd0, r_ovf, w_busy, w_full, w_empty};

    assign leds    = r_leds;
    assign uart_tx = r_tx;

    // Word RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_mem[w_ram_idx] <= WriteData;
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= WriteData[7:0];
        end
    end

    // TX FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req & ~w_push) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // LED register and free-running cycle counter (a write loads instead of counting).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds  <= 8'd0;
            r_cycle <= 32'd0;
        end else begin
            if (w_wr_led) begin
                r_leds <= WriteData[7:0];
            end
            if (w_wr_cycle) begin
                r_cycle <= WriteData;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
        end
    end

    // 8N1 serializer; r_div counts down from CLK_DIV-1 and advances on zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_fifo[r_rd_ptr];
                        r_tx    <= 1'b0;
                        r_div   <= DIV_LAST;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_div == '0) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_bit   <= 3'd0;
                        r_div   <= DIV_LAST;
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_div == '0) begin
                        r_div <= DIV_LAST;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_div == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Combinational read mux: RAM word or IO register selected by Address[3:2].
    always_comb begin
        ReadData = 32'd0;
        if (!w_io) begin
            ReadData = r_mem[w_ram_idx];
        end else begin
            case (w_sel)
                2'd0:    ReadData = {24'd0, r_leds};
                2'd1:    ReadData = 32'd0;
                2'd2:    ReadData = w_status;
                default: ReadData = r_cycle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_io_responder.sv
// Randomized bench for dmem_io_responder against a frame-timeline reference model.
module tb_dmem_io_responder;

    localparam int DIV   = 4;
    localparam int DEPTH = 8;
    localparam int WORDS = 1024;
    localparam int FRAME = 10 * DIV;

    localparam logic [31:0] A_LED  = 32'h0040_0000;
    localparam logic [31:0] A_TXD  = 32'h0040_0004;
    localparam logic [31:0] A_STAT = 32'h0040_0008;
    localparam logic [31:0] A_CYC  = 32'h0040_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic        uart_tx;

    dmem_io_responder #(
        .MEM_WORDS (WORDS),
        .FIFO_DEPTH(DEPTH),
        .CLK_DIV   (DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .ReadData (ReadData),
        .leds     (leds),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [int];
    logic [7:0]  m_q[$];
    logic [7:0]  m_leds;
    logic [31:0] m_cycle;
    logic        m_ovf;
    logic [7:0]  m_cur;
    int          m_left;   // clocks remaining in the frame on the line, 0 = idle

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        int p;
        int b;
        if (m_left == 0) return 1'b1;
        p = FRAME - m_left;
        b = p / DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s       = 32'd0;
        s[0]    = (m_q.size() == 0);
        s[1]    = (m_q.size() == DEPTH);
        s[2]    = (m_left != 0) || (m_q.size() != 0);
        s[3]    = m_ovf;
        s[12:8] = 5'(m_q.size());
        return s;
    endfunction

    task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit ok);
        int idx;
        ok = 1'b1;
        v  = 32'd0;
        if (!a[22]) begin
            idx = int'(a[11:2]);
            if (m_mem.exists(idx)) v = m_mem[idx];
            else ok = 1'b0;
        end else begin
            case (a[3:2])
                2'd0:    v = {24'd0, m_leds};
                2'd1:    v = 32'd0;
                2'd2:    v = model_status();
                default: v = m_cycle;
            endcase
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_left  = 0;
        m_leds  = 8'd0;
        m_cycle = 32'd0;
        m_ovf   = 1'b0;
        m_cur   = 8'd0;
    endtask

    // One rising edge of the model with the access presented during that cycle.
    task automatic model_clock(input logic [31:0] a, input logic [31:0] d, input bit we);
        bit         pop;
        bit         io;
        logic [1:0] sel;
        io  = a[22];
        sel = a[3:2];
        pop = (m_left == 0) && (m_q.size() != 0);
        if (we && io && sel == 2'd3) m_cycle = d;
        else m_cycle = m_cycle + 32'd1;
        if (we && !io) m_mem[int'(a[11:2])] = d;
        if (we && io && sel == 2'd0) m_leds = d[7:0];
        if (we && io && sel == 2'd2) m_ovf = 1'b0;
        if (pop) begin
            m_cur  = m_q.pop_front();
            m_left = FRAME;
        end else if (m_left > 0) begin
            m_left--;
        end
        if (we && io && sel == 2'd1) begin
            if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
    endtask

    // Present one access for one clock, checking all outputs before the edge.
    task automatic do_cycle(input logic [31:0] a, input logic [31:0] d, input bit we);
        logic [31:0] ev;
        bit          ok;
        Address   = a;
        WriteData = d;
        MemWrite  = we;
        #1;
        model_read(a, ev, ok);
        if (ok) check_val("rdata", ReadData, ev);
        check_val("uart_tx", 32'(uart_tx), 32'(model_tx()));
        check_val("leds", 32'(leds), 32'(m_leds));
        @(posedge clk);
        model_clock(a, d, we);
        #1;
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Address  = a;
        MemWrite = 1'b0;
        #1;
        check_val(tag, ReadData, exp);
    endtask

    task automatic do_reset();
        MemWrite = 1'b0;
        reset    = 1'b1;
        #1;
        model_reset();
        check_val("rst_uart_tx", 32'(uart_tx), 32'd1);
        check_val("rst_leds", 32'(leds), 32'd0);
        peek("rst_status", A_STAT, 32'h0000_0001);
        peek("rst_cycle", A_CYC, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bit          we;
        bit          found;

        reset     = 1'b1;
        Address   = 32'd0;
        WriteData = 32'd0;
        MemWrite  = 1'b0;
        model_reset();

        // Reset state
        do_reset();

        // RAM write, read-back and aliasing
        do_cycle(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        peek("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        do_cycle(32'h0000_0010, 32'd0, 1'b0);
        peek("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
        do_cycle(32'h0000_1010, 32'd0, 1'b0);

        // Single UART frame of 0xA5 with busy tracking
        do_cycle(A_TXD, 32'h0000_00A5, 1'b1);
        repeat (45) do_cycle(A_STAT, 32'd0, 1'b0);
        peek("frame_done_status", A_STAT, 32'h0000_0001);

        // Overflow: nine pushes while the first frame is on the line
        do_cycle(A_TXD, 32'h0000_0011, 1'b1);
        do_cycle(A_STAT, 32'd0, 1'b0);
        for (int i = 0; i < 9; i++) do_cycle(A_TXD, 32'h20 + i, 1'b1);
        peek("ovf_status", A_STAT, 32'h0000_080E);
        do_cycle(A_STAT, $urandom, 1'b1);
        peek("ovf_clear", A_STAT, 32'h0000_0806);
        repeat (400) do_cycle(A_STAT, 32'd0, 1'b0);
        peek("drain_status", A_STAT, 32'h0000_0001);

        // Cycle counter load and wrap
        do_cycle(A_CYC, 32'hFFFF_FFFE, 1'b1);
        do_cycle(A_CYC, 32'd0, 1'b0);
        peek("cyc_ffffffff", A_CYC, 32'hFFFF_FFFF);
        do_cycle(A_CYC, 32'd0, 1'b0);
        peek("cyc_wrap0", A_CYC, 32'h0000_0000);
        do_cycle(A_CYC, 32'd0, 1'b0);
        peek("cyc_wrap1", A_CYC, 32'h0000_0001);

        // Reset during data bit 3, then silence until a new push
        do_cycle(A_TXD, 32'h0000_00C3 ^ ($urandom & 32'h3C), 1'b1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_left != 0 && ((FRAME - m_left) / DIV) == 4) found = 1'b1;
            else do_cycle(A_LED, 32'd0, 1'b0);
        end
        check_val("reach_bit3", 32'(found), 32'd1);
        do_reset();
        repeat (60) do_cycle(A_STAT, 32'd0, 1'b0);
        peek("post_rst_status", A_STAT, 32'h0000_0001);
        do_cycle(32'h0000_0010, 32'd0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            a  = $urandom;
            d  = $urandom;
            we = 1'b0;
            case ($urandom_range(0, 9))
                0: begin a[22] = 1'b0; a[11:2] = 10'($urandom_range(0, 15)); we = 1'b1; end
                1, 2: begin a[22] = 1'b0; a[11:2] = 10'($urandom_range(0, 15)); end
                3: begin a[22] = 1'b1; a[3:2] = 2'd0; we = 1'($urandom); end
                4: begin a[22] = 1'b1; a[3:2] = 2'd1; we = 1'b1; end
                5: begin a[22] = 1'b1; a[3:2] = 2'd2; end
                6: begin a[22] = 1'b1; a[3:2] = 2'd2; we = ($urandom_range(0, 3) == 0); end
                7: begin a[22] = 1'b1; a[3:2] = 2'd3; end
                8: begin a[22] = 1'b1; a[3:2] = 2'd3; we = ($urandom_range(0, 7) == 0); end
                default: begin a[22] = 1'b1; we = 1'($urandom); end
            endcase
            do_cycle(a, d, we);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
